// File: rtl/arduino_cmd_rx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arduino_cmd_rx_if : UART line in, validated drive command out     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface arduino_cmd_rx_if;
   logic       uart_rx;
   logic [7:0] arduino_command;
   logic       cmd_valid;
   logic       frame_err;
   logic       timeout;

   modport master (
      output uart_rx,
      input  arduino_command,
      input  cmd_valid,
      input  frame_err,
      input  timeout
   );

   modport slave (
      input  uart_rx,
      output arduino_command,
      output cmd_valid,
      output frame_err,
      output timeout
   );
endinterface
`default_nettype wire

// File: rtl/arduino_cmd_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arduino_cmd_rx : UART receiver, command filter and link watchdog  |
// | Option macro CMD_PARITY_EN selects 8E1 framing (default 8N1).     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module arduino_cmd_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int TIMEOUT_MS = 250
) (
   input  logic             clk,
   input  logic             rst_n,
   arduino_cmd_rx_if.slave  bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int TIMEOUT_CLKS = CLK_FREQ / 1000 * TIMEOUT_MS;
   localparam int BW           = $clog2(CLKS_PER_BIT + 1);
   localparam int WW           = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CLKS);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            done_q, done_d;
   logic [7:0]      cmd_q, cmd_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            timeout_q, timeout_d;
   logic [WW-1:0]   wd_q, wd_d;
`ifdef CMD_PARITY_EN
   logic            par_err_q, par_err_d;
`endif

   logic rx_s;
   logic accept;
   assign rx_s = sync2_q;

   function automatic logic is_legal(input logic [7:0] b);
      case (b)
         8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
         8'h06, 8'h08, 8'h09, 8'h0A, 8'h0C: is_legal = 1'b1;
         default:                           is_legal = 1'b0;
      endcase
   endfunction

   // The shift register is untouched outside DATA, so it still holds the byte
   // one cycle after the stop-bit sample.
   assign accept = done_q && is_legal(shift_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         baud_q      <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         done_q      <= 1'b0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
         wd_q        <= '0;
`ifdef CMD_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= bus.uart_rx;
         sync2_q     <= sync1_q;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         done_q      <= done_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
         wd_q        <= wd_d;
`ifdef CMD_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      done_d      = 1'b0;
      frame_err_d = 1'b0;
`ifdef CMD_PARITY_EN
      par_err_d   = par_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (baud_q == HALF_END) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_q == BIT_END) begin
               baud_d    = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef CMD_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`ifdef CMD_PARITY_EN
         S_PARITY: begin
            if (baud_q == BIT_END) begin
               baud_d    = '0;
               par_err_d = ^{shift_q, rx_s};
               state_d   = S_STOP;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`endif
         S_STOP: begin
            if (baud_q == BIT_END) begin
               baud_d = '0;
               if (!rx_s) begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT_IDLE;
               end else begin
`ifdef CMD_PARITY_EN
                  frame_err_d = par_err_q;
                  done_d      = !par_err_q;
`else
                  done_d      = 1'b1;
`endif
                  state_d     = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Acceptance takes priority over watchdog expiry on the same edge.
   always_comb begin
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      timeout_d   = timeout_q;
      wd_d        = wd_q;
      if (accept) begin
         cmd_d       = shift_q;
         cmd_valid_d = 1'b1;
         timeout_d   = 1'b0;
         wd_d        = '0;
      end else if (wd_q != WD_MAX) begin
         wd_d = wd_q + WW'(1);
         if (wd_q == WD_LAST) begin
            cmd_d     = 8'h00;
            timeout_d = 1'b1;
         end
      end
   end

   assign bus.arduino_command = cmd_q;
   assign bus.cmd_valid       = cmd_valid_q;
   assign bus.frame_err       = frame_err_q;
   assign bus.timeout         = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_arduino_cmd_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_arduino_cmd_rx : scoreboard bench for arduino_cmd_rx           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_arduino_cmd_rx;

   localparam int CLK_FREQ     = 1000000;
   localparam int BAUD         = 100000;
   localparam int TIMEOUT_MS   = 1;
   localparam int CPB          = CLK_FREQ / BAUD;
   localparam int TIMEOUT_CLKS = CLK_FREQ / 1000 * TIMEOUT_MS;
`ifdef CMD_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      bit         err;
      logic [7:0] b;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   arduino_cmd_rx_if bus();

   arduino_cmd_rx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .TIMEOUT_MS (TIMEOUT_MS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t       exp_q[$];
   logic [7:0] exp_cmd = 8'h00;
   logic [7:0] legal_tbl [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                  8'h06, 8'h08, 8'h09, 8'h0A, 8'h0C};
   int  n_chk = 0;
   int  n_pass = 0;
   int  cyc = 0;
   int  last_valid_cyc = 0;
   int  to_lat = 0;
   logic [7:0] to_cmd = 8'hFF;
   logic to_valid = 1'b0;
   bit  to_rise = 1'b0;
   bit  wd_phase = 1'b0;
   logic prev_valid = 1'b0;
   logic prev_to = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit legal(input logic [7:0] b);
      return b inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                       8'h06, 8'h08, 8'h09, 8'h0A, 8'h0C};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic drive_bit(input logic v);
      bus.uart_rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   // Stop bit is left on the line; a low stop bit keeps the line low on return.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_flip);
      exp_t e;
      bit   bad;
      bad = !stop_ok || (PAR_EN && par_flip);
      @(negedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef CMD_PARITY_EN
      drive_bit((^b) ^ par_flip);
`endif
      if (bad || legal(b)) begin
         e.err = bad;
         e.b   = b;
         exp_q.push_back(e);
      end
      drive_bit(stop_ok);
   endtask

   task automatic idle(input int n);
      bus.uart_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every output pulse and checks held state.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.cmd_valid || bus.frame_err)
            chk("valid_ferr_exclusive", 32'(bus.cmd_valid & bus.frame_err), 0);
         if (bus.cmd_valid) begin
            last_valid_cyc = cyc;
            chk("cmd_valid_single_cycle", 32'(prev_valid), 0);
            chk("pending_on_cmd_valid", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("kind_is_cmd", 32'(e.err), 0);
               chk("cmd_value", 32'(bus.arduino_command), 32'(e.b));
               chk("timeout_low_on_accept", 32'(bus.timeout), 0);
               exp_cmd = e.b;
            end
         end
         if (bus.frame_err) begin
            chk("pending_on_frame_err", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("kind_is_frame_err", 32'(e.err), 1);
            end
         end
         if (!wd_phase) begin
            chk("cmd_held", 32'(bus.arduino_command), 32'(exp_cmd));
            chk("timeout_low", 32'(bus.timeout), 0);
         end
         if (bus.timeout && !prev_to) begin
            to_rise  = 1'b1;
            to_lat   = cyc - last_valid_cyc;
            to_cmd   = bus.arduino_command;
            to_valid = bus.cmd_valid;
         end
         prev_valid = bus.cmd_valid;
         prev_to    = bus.timeout;
      end
   end

   initial begin
      logic [7:0] b;
      bit         bad;
      bit         want_legal;
      int         quiet;
      int         k;

      bus.uart_rx = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_cmd", 32'(bus.arduino_command), 0);
      chk("reset_cmd_valid", 32'(bus.cmd_valid), 0);
      chk("reset_frame_err", 32'(bus.frame_err), 0);
      chk("reset_timeout", 32'(bus.timeout), 0);
      rst_n = 1'b1;
      idle(5);

      send_byte(8'h01, 1'b1, 1'b0);
      idle(10);
      send_byte(8'h03, 1'b1, 1'b0);
      idle(10);
      send_byte(8'h07, 1'b1, 1'b0);
      idle(10);
      chk("illegal_keeps_cmd", 32'(bus.arduino_command), 32'h03);

      send_byte(8'h5A, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      idle(5);
      send_byte(8'h0C, 1'b1, 1'b0);
      idle(10);

      bus.uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      idle(20);
      send_byte(8'h05, 1'b1, 1'b0);
      idle(10);

`ifdef CMD_PARITY_EN
      send_byte(8'h03, 1'b1, 1'b1);
      idle(10);
      chk("parity_err_keeps_cmd", 32'(bus.arduino_command), 32'h05);
      send_byte(8'h03, 1'b1, 1'b0);
      idle(10);
`endif

      // Never more than two non-accepted frames in a row keeps the watchdog quiet.
      quiet = 0;
      for (int i = 0; i < 24; i++) begin
         bad        = ($urandom_range(9) == 0);
         want_legal = ($urandom_range(3) != 0);
         if (quiet >= 2) begin
            bad        = 1'b0;
            want_legal = 1'b1;
         end
         if (want_legal) begin
            b = legal_tbl[$urandom_range(10)];
         end else begin
            b = 8'($urandom);
            if (legal(b)) b = b | 8'h80;
         end
         send_byte(b, !bad, 1'b0);
         if (bad) repeat ($urandom_range(5, 30)) @(negedge clk);
         quiet = (!bad && legal(b)) ? 0 : quiet + 1;
         idle($urandom_range(3, 30));
      end

      wd_phase = 1'b1;
      to_rise  = 1'b0;
      send_byte(8'h09, 1'b1, 1'b0);
      bus.uart_rx = 1'b1;
      k = 0;
      while (!to_rise && k < 2 * TIMEOUT_CLKS) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_rose", 32'(to_rise), 1);
      chk("timeout_latency", 32'(to_lat), 32'(TIMEOUT_CLKS));
      chk("timeout_forces_stop", 32'(to_cmd), 0);
      chk("timeout_no_cmd_valid", 32'(to_valid), 0);
      idle(20);
      chk("timeout_held", 32'(bus.timeout), 1);
      chk("timeout_cmd_zero", 32'(bus.arduino_command), 0);
      exp_cmd = 8'h00;
      send_byte(8'h02, 1'b1, 1'b0);
      idle(5);
      chk("timeout_cleared", 32'(bus.timeout), 0);
      chk("cmd_after_timeout", 32'(bus.arduino_command), 32'h02);
      wd_phase = 1'b0;

      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
